// File: rtl/flt2int_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flt2int_unit_pkg
// Purpose  : Shared constants and the FSM state type for the half-precision
//            float to 16-bit integer converter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package flt2int_unit_pkg;

  // Half-precision layout and integer result width.
  localparam int c_EXP_W = 5;
  localparam int c_MAN_W = 10;
  localparam int c_BIAS  = 15;
  localparam int c_INT_W = 16;
  localparam int c_CNT_W = 4;

  // Exponent thresholds.
  // Below BIAS-1 the magnitude is under 0.5 and always rounds to zero.
  localparam logic [c_EXP_W-1:0] c_EXP_ZERO_MAX = 5'(c_BIAS - 2);          // 13
  // At and above BIAS+15 the magnitude cannot fit a signed 16-bit result.
  localparam logic [c_EXP_W-1:0] c_EXP_SAT_MIN  = 5'(c_BIAS + 15);         // 30
  // Exponent at which the 11-bit significand is already an integer.
  localparam logic [c_EXP_W-1:0] c_EXP_PIVOT    = 5'(c_BIAS + c_MAN_W);    // 25

  localparam logic [c_INT_W-1:0] c_INT_MAX = 16'h7FFF;
  localparam logic [c_INT_W-1:0] c_INT_MIN = 16'h8000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_LO  = 4'd1,
    S_RD_HI  = 4'd2,
    S_DECODE = 4'd3,
    S_SHIFT  = 4'd4,
    S_ROUND  = 4'd5,
    S_WR_LO  = 4'd6,
    S_WR_HI  = 4'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/flt2int_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : flt2int_unit_if
// Purpose  : Start/done handshake plus the shared byte-wide data memory port.
// Ports    : start      request one conversion
//            done       conversion complete, held until next accepted start
//            mem_addr   data memory byte address
//            mem_rd     read enable
//            mem_wr     write enable
//            mem_wdata  write data
//            mem_rdata  read data, combinational from mem_addr
//            master = controller/memory side, slave = converter side
// Revision : 1.0 - initial release
// ============================================================================
interface flt2int_unit_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output start,
    output mem_rdata,
    input  done,
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata
  );

  modport slave (
    input  start,
    input  mem_rdata,
    output done,
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/flt2int_unit_rne_rounder.sv
`default_nettype none
// ============================================================================
// Module   : flt2int_unit_rne_rounder
// Purpose  : Combinational round-to-nearest-even on a shifted magnitude,
//            followed by two's-complement sign application.
// Ports    : i_mag     unsigned magnitude after shifting
//            i_guard   first bit shifted out
//            i_sticky  OR of all bits shifted out after the guard bit
//            i_sgn     sign of the original float
//            o_res     signed 16-bit result
// Revision : 1.0 - initial release
// ============================================================================
module flt2int_unit_rne_rounder
  import flt2int_unit_pkg::*;
(
  input  wire logic [c_INT_W-1:0] i_mag,
  input  wire logic               i_guard,
  input  wire logic               i_sticky,
  input  wire logic               i_sgn,
  output logic      [c_INT_W-1:0] o_res
);

  logic               w_inc;
  logic [c_INT_W-1:0] w_mag_rnd;

  // Round up when past the halfway point, or exactly halfway with an odd lsb.
  assign w_inc     = i_guard & (i_sticky | i_mag[0]);
  // Magnitude stays <= 2^15-1 for every non-saturating exponent, so no carry-out.
  assign w_mag_rnd = i_mag + {{(c_INT_W-1){1'b0}}, w_inc};
  assign o_res     = i_sgn ? (c_INT_W'(0) - w_mag_rnd) : w_mag_rnd;

endmodule
`default_nettype wire

// File: rtl/flt2int_unit.sv
`default_nettype none
// ============================================================================
// Module   : flt2int_unit
// Purpose  : Reads a half-precision float from data memory, converts it to a
//            16-bit two's-complement integer (round-to-nearest-even,
//            saturating, no subnormals) and writes the result back.
// Ports    : clk    clock
//            reset  synchronous, active-high
//            bus    flt2int_unit_if.slave (start/done + data memory port)
// Revision : 1.0 - initial release
// ============================================================================
module flt2int_unit
  import flt2int_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SRC_ADDR = 8'd4,
  parameter logic [ADDR_W-1:0] DST_ADDR = 8'd6
) (
  input  wire logic     clk,
  input  wire logic     reset,
  flt2int_unit_if.slave bus
);

  state_t r_state;
  state_t w_next;

  logic [7:0]         r_lo;
  logic [7:0]         r_hi;
  logic [c_INT_W-1:0] r_mag;
  logic               r_guard;
  logic               r_sticky;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_left;
  logic               r_sat;
  logic [c_INT_W-1:0] r_res;
  logic               r_done;

  logic               w_sgn;
  logic [c_EXP_W-1:0] w_exp;
  logic [c_MAN_W-1:0] w_man;
  logic               w_is_zero;
  logic               w_is_sat;
  logic               w_is_right;
  logic [c_CNT_W-1:0] w_n;
  logic [c_INT_W-1:0] w_rnd_res;

  logic [ADDR_W-1:0]  w_addr;
  logic               w_rd;
  logic               w_wr;
  logic [7:0]         w_wdata;

  // --------------------------------------------------------------------------
  // Field decode of the latched float (valid from DECODE onwards)
  // --------------------------------------------------------------------------
  assign w_sgn      = r_hi[7];
  assign w_exp      = r_hi[6:2];
  assign w_man      = {r_hi[1:0], r_lo};
  assign w_is_zero  = (w_exp <= c_EXP_ZERO_MAX);   // also covers exp==0
  assign w_is_sat   = (w_exp >= c_EXP_SAT_MIN);    // also covers inf/NaN
  assign w_is_right = (w_exp <  c_EXP_PIVOT);

  always_comb begin
    w_n = '0;
    if (!w_is_zero && !w_is_sat) begin
      if (w_is_right) w_n = c_CNT_W'(c_EXP_PIVOT - w_exp);
      else            w_n = c_CNT_W'(w_exp - c_EXP_PIVOT);
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_RD_LO;
      S_RD_LO:  w_next = S_RD_HI;
      S_RD_HI:  w_next = S_DECODE;
      S_DECODE: w_next = (w_n != '0) ? S_SHIFT : S_ROUND;
      S_SHIFT:  if (r_cnt == c_CNT_W'(1)) w_next = S_ROUND;
      S_ROUND:  w_next = S_WR_LO;
      S_WR_LO:  w_next = S_WR_HI;
      S_WR_HI:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: memory port outputs (all zero outside read/write states)
  // --------------------------------------------------------------------------
  always_comb begin
    w_addr  = '0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_wdata = '0;
    case (r_state)
      S_RD_LO: begin
        w_addr = SRC_ADDR;
        w_rd   = 1'b1;
      end
      S_RD_HI: begin
        w_addr = SRC_ADDR + ADDR_W'(1);
        w_rd   = 1'b1;
      end
      S_WR_LO: begin
        w_addr  = DST_ADDR;
        w_wr    = 1'b1;
        w_wdata = r_res[7:0];
      end
      S_WR_HI: begin
        w_addr  = DST_ADDR + ADDR_W'(1);
        w_wr    = 1'b1;
        w_wdata = r_res[15:8];
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = w_addr;
  assign bus.mem_rd    = w_rd;
  assign bus.mem_wr    = w_wr;
  assign bus.mem_wdata = w_wdata;
  assign bus.done      = r_done;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo     <= '0;
      r_hi     <= '0;
      r_mag    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_sat    <= 1'b0;
      r_res    <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) r_done <= 1'b0;
        S_RD_LO: r_lo <= bus.mem_rdata;
        S_RD_HI: r_hi <= bus.mem_rdata;
        S_DECODE: begin
          // Zero class loads an empty magnitude so ROUND yields 0 (also for -0).
          r_mag    <= w_is_zero ? '0 : {{(c_INT_W-c_MAN_W-1){1'b0}}, 1'b1, w_man};
          r_guard  <= 1'b0;
          r_sticky <= 1'b0;
          r_cnt    <= w_n;
          r_left   <= !w_is_right;
          r_sat    <= w_is_sat;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - c_CNT_W'(1);
          if (r_left) begin
            r_mag <= r_mag << 1;
          end else begin
            // Previous guard joins sticky; the bit falling out becomes guard.
            r_mag    <= r_mag >> 1;
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end
        end
        S_ROUND: r_res  <= r_sat ? (w_sgn ? c_INT_MIN : c_INT_MAX) : w_rnd_res;
        S_WR_HI: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  flt2int_unit_rne_rounder u_rounder (
    .i_mag    (r_mag),
    .i_guard  (r_guard),
    .i_sticky (r_sticky),
    .i_sgn    (w_sgn),
    .o_res    (w_rnd_res)
  );

endmodule
`default_nettype wire

// File: tb/tb_flt2int_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flt2int_unit
// Purpose  : Self-checking bench for flt2int_unit. A byte-wide memory model
//            serves the converter; expected results and latencies come from an
//            arithmetic reference model and pass through a scoreboard queue.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_flt2int_unit;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flt2int_unit_if #(.ADDR_W(8)) bus ();

  flt2int_unit #(
    .ADDR_W   (8),
    .SRC_ADDR (8'd4),
    .DST_ADDR (8'd6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: combinational read, writes from the DUT or bench loader.
  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_waddr;
  logic [7:0] tb_wdata;
  int         wr_cnt;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (tb_we)           mem[tb_waddr] <= tb_wdata;
    else if (bus.mem_wr) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt            <= wr_cnt + 1;
    end
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Read and write enables must never be asserted together.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      assert (!(bus.mem_rd && bus.mem_wr)) else begin
        errors++;
        $error("FAIL rd_wr_excl: observed rd=%0b wr=%0b expected not both", bus.mem_rd, bus.mem_wr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: value = {1,man} * 2^(exp-25), rounded half-to-even on integers.
  function automatic logic [15:0] ref_conv(input logic [15:0] f);
    int e, v, s, q, rem, half, mag;
    e = int'(f[14:10]);
    v = 1024 + int'(f[9:0]);
    if (e >= 30) return f[15] ? 16'h8000 : 16'h7FFF;
    if (e <= 13) mag = 0;
    else if (e >= 25) mag = v * (1 << (e - 25));
    else begin
      s    = 25 - e;
      q    = v / (1 << s);
      rem  = v - q * (1 << s);
      half = 1 << (s - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      mag = q;
    end
    return f[15] ? 16'(-mag) : 16'(mag);
  endfunction

  function automatic int ref_n(input logic [15:0] f);
    int e;
    e = int'(f[14:10]);
    if (e <= 13 || e >= 30) return 0;
    if (e >= 25) return e - 25;
    return 25 - e;
  endfunction

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    #1;
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // One conversion. Latency is counted in clock edges from the cycle in which
  // start is raised, the sampling edge being edge 1. start is re-asserted
  // during cycles busy_from..busy_to (edge indices) to exercise the ignore path.
  task automatic convert(input logic [15:0] f, input string tag,
                         input int busy_from, input int busy_to);
    exp_t e, x;
    int   cyc, wr0;
    logic got;
    load(8'd4, f[7:0]);
    load(8'd5, f[15:8]);
    e.res = ref_conv(f);
    e.lat = 7 + ref_n(f);
    sb.push_back(e);
    wr0 = wr_cnt;
    bus.start = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    cyc = 1;
    bus.start = 1'b0;
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin got = 1'b1; break; end
      bus.start = (cyc >= busy_from && cyc <= busy_to);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    x = sb.pop_front();
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(cyc), 32'(x.lat));
      chk({tag, "_lo"}, 32'(mem[6]), 32'(x.res[7:0]));
      chk({tag, "_hi"}, 32'(mem[7]), 32'(x.res[15:8]));
      chk({tag, "_wrcnt"}, 32'(wr_cnt - wr0), 32'd2);
      if (busy_to >= busy_from) begin
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_held"}, 32'(bus.done), 32'd1);
        chk({tag, "_one_result"}, 32'(wr_cnt - wr0), 32'd2);
      end
    end
  endtask

  initial begin
    logic [15:0] f;
    int          wr0;
    reset = 1'b1; bus.start = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",  32'(bus.done),      32'd0);
    chk("rst_rd",    32'(bus.mem_rd),    32'd0);
    chk("rst_wr",    32'(bus.mem_wr),    32'd0);
    chk("rst_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    reset = 1'b0;
    @(posedge clk);

    convert(16'h3C00, "one",      0, -1);
    convert(16'h4100, "p2_5",     0, -1);
    convert(16'h4300, "p3_5",     0, -1);
    convert(16'hBE00, "m1_5",     0, -1);
    convert(16'h3A00, "p0_75",    0, -1);
    convert(16'h3800, "p0_5",     0, -1);
    convert(16'h3666, "small",    0, -1);
    convert(16'h7BFF, "max_half", 0, -1);
    convert(16'hF800, "m32768",   0, -1);
    convert(16'h7C00, "inf",      0, -1);
    convert(16'h8000, "neg_zero", 0, -1);
    convert(16'h77FF, "exp29",    0, -1);
    convert(16'h6400, "exp25",    0, -1);
    convert(16'h0123, "subnorm",  0, -1);
    convert(16'hFE00, "nan_neg",  0, -1);

    // start held from the second edge through the edge on which done rises
    convert(16'h4300, "busy", 2, 15);

    // Reset while shifting: no writes, done cleared, destination untouched.
    load(8'd6, 8'hA5);
    load(8'd7, 8'h5A);
    load(8'd4, 8'h00);
    load(8'd5, 8'h41);
    wr0 = wr_cnt;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_done", 32'(bus.done),   32'd0);
    chk("rst_mid_wr",   32'(bus.mem_wr), 32'd0);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("rst_mid_lo",    32'(mem[6]),         32'hA5);
    chk("rst_mid_hi",    32'(mem[7]),         32'h5A);
    chk("rst_mid_wrcnt", 32'(wr_cnt - wr0),   32'd0);
    chk("rst_mid_done2", 32'(bus.done),       32'd0);

    // Random floats against the reference model.
    for (int i = 0; i < 1000; i++) begin
      f = 16'($urandom);
      convert(f, "rand", 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
